// File: rtl/ysyx_25050147_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_25050147_ifu -- instruction fetch unit
//
// Fetches one 32-bit instruction at a time from instruction memory. It holds
// each instruction for decode until the instruction retires, then computes
// the next PC (pc+4 or a redirect target). A halt that arrives with a retire
// stops fetching cleanly. A memory access fault, or a misaligned redirect
// target, stops fetching with fault raised.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   imem_req_valid/ready/addr  fetch request handshake and address
//   imem_rsp_valid/data/err    fetch response (always accepted)
//   inst_valid/ready           instruction handshake towards decode
//   inst, inst_pc              held instruction word and its PC
//   redirect_valid/pc          next-PC override, sampled on retire only
//   halt                       stop request, sampled on retire only
//   halted, fault              stopped / stopped because of an error
//   inst_count                 retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module ysyx_25050147_ifu #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,

    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,

    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             imem_rsp_err,

    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  inst_pc,

    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             halt,

    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] inst_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_STOP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic [XLEN-1:0]    inst_pc_q, inst_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic               retire;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cnt_d     = cnt_q;
        fault_d   = fault_q;
        retire    = 1'b0;

        unique case (state_q)
            S_REQ: begin
                // Request valid is constant in this state, so acceptance
                // only depends on ready; address is pc_q and cannot move.
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        fault_d = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (inst_ready) begin
                    retire = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    // Halt wins over redirect; a faulting redirect leaves
                    // pc at the retiring instruction.
                    if (halt) begin
                        state_d = S_STOP;
                    end else if (redirect_valid) begin
                        if (redirect_pc[1:0] != 2'b00) begin
                            fault_d = 1'b1;
                            state_d = S_STOP;
                        end else begin
                            pc_d    = redirect_pc;
                            state_d = S_REQ;
                        end
                    end else begin
                        pc_d    = pc_q + XLEN'(4);
                        state_d = S_REQ;
                    end
                end
            end

            S_STOP: begin
                state_d = S_STOP;
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Gated with rst so no request escapes while reset is held; the
        // request rises combinationally as soon as reset drops.
        imem_req_valid = (state_q == S_REQ) && !rst;
        imem_req_addr  = pc_q;
        inst_valid     = (state_q == S_HOLD);
        inst           = inst_q;
        inst_pc        = inst_pc_q;
        halted         = (state_q == S_STOP);
        fault          = fault_q;
        inst_count     = cnt_q;
    end

endmodule

// File: tb/tb_ysyx_25050147_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25050147_ifu -- self-checking bench for ysyx_25050147_ifu
//
// Inputs are driven at the falling edge. Each step() first predicts, from
// the transaction rules, what the coming rising edge does. It then waits
// for the next falling edge and compares every DUT output with the
// prediction. Directed sections pin literal values; a randomized section
// then covers stalls, redirects, halts, faults, wrap and mid-flight resets.
// The counter is built narrow so that its wrap is reached.
// ---------------------------------------------------------------------------
module tb_ysyx_25050147_ifu;

    localparam int unsigned TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                imem_req_valid, imem_req_ready;
    logic [31:0]         imem_req_addr;
    logic                imem_rsp_valid, imem_rsp_err;
    logic [31:0]         imem_rsp_data;
    logic                inst_valid, inst_ready;
    logic [31:0]         inst, inst_pc;
    logic                redirect_valid, halt;
    logic [31:0]         redirect_pc;
    logic                halted, fault;
    logic [TB_CNT_W-1:0] inst_count;

    ysyx_25050147_ifu #(
        .XLEN     (32),
        .RESET_PC (32'h8000_0000),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted),
        .fault          (fault),
        .inst_count     (inst_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: phase 0 = need to request, 1 = request
    // outstanding, 2 = instruction offered to decode.
    int                  m_phase;
    logic [31:0]         m_pc, m_inst, m_ipc;
    logic [TB_CNT_W-1:0] m_cnt;
    logic                m_stop, m_fault;

    int          cyc = 0;
    logic [31:0] acc_q[$];
    int          ret_cyc[$];

    int unsigned p_rsp = 100;
    int unsigned p_err = 0;
    logic        force_rsp = 1'b0;

    function automatic bit chance(int unsigned p);
        return $urandom_range(99, 0) < p;
    endfunction

    function automatic logic [31:0] memword(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic exp_req;
        exp_req = !rst && !m_stop && (m_phase == 0);
        chk("imem_req_valid", 64'(imem_req_valid), 64'(exp_req));
        if (exp_req) chk("imem_req_addr", 64'(imem_req_addr), 64'(m_pc));
        chk("inst_valid", 64'(inst_valid), 64'(!m_stop && (m_phase == 2)));
        chk("inst", 64'(inst), 64'(m_inst));
        chk("inst_pc", 64'(inst_pc), 64'(m_ipc));
        chk("halted", 64'(halted), 64'(m_stop));
        chk("fault", 64'(fault), 64'(m_fault));
        chk("inst_count", 64'(inst_count), 64'(m_cnt));
    endtask

    // Called at a falling edge with the caller's inputs already set.
    task automatic step();
        imem_rsp_valid = force_rsp || (!m_stop && m_phase == 1 && chance(p_rsp));
        imem_rsp_err   = imem_rsp_valid ? chance(p_err) : chance(50);
        imem_rsp_data  = force_rsp ? 32'hDEAD_BEEF : memword(m_pc);

        if (rst) begin
            m_phase = 0; m_pc = 32'h8000_0000; m_inst = '0; m_ipc = '0;
            m_cnt = '0; m_stop = 1'b0; m_fault = 1'b0;
        end else if (!m_stop) begin
            if (m_phase == 0) begin
                if (imem_req_ready) begin
                    acc_q.push_back(m_pc);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        m_fault = 1'b1; m_stop = 1'b1;
                    end else begin
                        m_inst = imem_rsp_data; m_ipc = m_pc; m_phase = 2;
                    end
                end
            end else if (inst_ready) begin
                m_cnt = m_cnt + 1'b1;
                ret_cyc.push_back(cyc);
                if (halt) m_stop = 1'b1;
                else if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
                    m_fault = 1'b1; m_stop = 1'b1;
                end else begin
                    m_pc = redirect_valid ? redirect_pc : m_pc + 32'd4;
                    m_phase = 0;
                end
            end
        end
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drv(logic rr, logic ir, logic rv, logic [31:0] rp, logic h);
        imem_req_ready = rr; inst_ready = ir; redirect_valid = rv;
        redirect_pc = rp; halt = h;
        step();
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; halt = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = '0;
        m_phase = 0; m_pc = 32'h8000_0000; m_inst = '0; m_ipc = '0;
        m_cnt = '0; m_stop = 1'b0; m_fault = 1'b0;

        // Reset values
        do_reset(3);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_count", 64'(inst_count), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);

        // Zero-wait memory, decode always ready
        acc_q.delete(); ret_cyc.delete();
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (9) step();
        chk("zw_accepts", 64'(acc_q.size()), 64'd3);
        if (acc_q.size() == 3) begin
            chk("zw_addr0", 64'(acc_q[0]), 64'h8000_0000);
            chk("zw_addr1", 64'(acc_q[1]), 64'h8000_0004);
            chk("zw_addr2", 64'(acc_q[2]), 64'h8000_0008);
        end
        chk("zw_retires", 64'(ret_cyc.size()), 64'd3);
        if (ret_cyc.size() == 3) begin
            chk("zw_gap1", 64'(ret_cyc[1] - ret_cyc[0]), 64'd3);
            chk("zw_gap2", 64'(ret_cyc[2] - ret_cyc[1]), 64'd3);
        end
        chk("zw_count", 64'(inst_count), 64'd3);

        // Back-pressure on both handshakes
        inst_ready = 1'b0;
        imem_req_ready = 1'b0;
        repeat (4) begin
            step();
            chk("bp_addr", 64'(imem_req_addr), 64'h8000_000C);
        end
        imem_req_ready = 1'b1; step();
        imem_req_ready = 1'b0; step();
        repeat (2) begin
            step();
            chk("bp_inst_pc", 64'(inst_pc), 64'h8000_000C);
            chk("bp_inst", 64'(inst), 64'(memword(32'h8000_000C)));
        end
        inst_ready = 1'b1; step();
        chk("bp_count", 64'(inst_count), 64'd4);
        chk("bp_next_addr", 64'(imem_req_addr), 64'h8000_0010);

        // Redirect only counts on retire
        do_reset(2);
        drv(1, 1, 1, 32'h8000_0200, 0);
        drv(1, 1, 1, 32'h8000_0200, 0);
        drv(1, 1, 0, 32'h0, 0);
        chk("rd_ignored", 64'(imem_req_addr), 64'h8000_0004);
        drv(1, 1, 1, 32'h8000_0200, 0);
        drv(1, 1, 1, 32'h8000_0200, 0);
        drv(1, 1, 1, 32'h8000_0100, 0);
        chk("rd_target", 64'(imem_req_addr), 64'h8000_0100);
        chk("rd_req_valid", 64'(imem_req_valid), 64'd1);

        // Halt beats redirect
        drv(1, 1, 0, 32'h0, 1);
        drv(1, 1, 0, 32'h0, 1);
        drv(1, 1, 1, 32'h8000_0300, 1);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_fault", 64'(fault), 64'd0);
        chk("halt_count", 64'(inst_count), 64'd3);
        repeat (5) drv(1, 1, 0, 32'h0, 0);
        chk("halt_count_hold", 64'(inst_count), 64'd3);
        chk("halt_no_req", 64'(imem_req_valid), 64'd0);

        // Access fault
        do_reset(2);
        p_err = 100;
        drv(1, 1, 0, 32'h0, 0);
        drv(1, 1, 0, 32'h0, 0);
        p_err = 0;
        chk("err_fault", 64'(fault), 64'd1);
        chk("err_halted", 64'(halted), 64'd1);
        chk("err_inst_valid", 64'(inst_valid), 64'd0);
        repeat (3) drv(1, 1, 0, 32'h0, 0);

        // Misaligned redirect
        do_reset(2);
        drv(1, 1, 0, 32'h0, 0);
        drv(1, 1, 0, 32'h0, 0);
        drv(1, 1, 1, 32'h8000_0102, 0);
        chk("mis_fault", 64'(fault), 64'd1);
        chk("mis_halted", 64'(halted), 64'd1);
        chk("mis_count", 64'(inst_count), 64'd1);

        // Reset while waiting, response arrives during and after reset
        do_reset(2);
        drv(1, 0, 0, 32'h0, 0);
        rst = 1'b1; force_rsp = 1'b1;
        repeat (2) step();
        rst = 1'b0; imem_req_ready = 1'b0;
        step();
        force_rsp = 1'b0;
        chk("late_addr", 64'(imem_req_addr), 64'h8000_0000);
        chk("late_req_valid", 64'(imem_req_valid), 64'd1);
        chk("late_count", 64'(inst_count), 64'd0);
        drv(1, 1, 0, 32'h0, 0);
        drv(1, 1, 0, 32'h0, 0);
        drv(1, 1, 0, 32'h0, 0);
        chk("late_inst_pc", 64'(inst_pc), 64'h8000_0000);
        chk("late_count1", 64'(inst_count), 64'd1);

        // Randomized traffic
        do_reset(2);
        p_rsp = 50; p_err = 3;
        for (int i = 0; i < 3000; i++) begin
            rst = (m_stop && chance(30)) || chance(1);
            imem_req_ready = chance(60);
            inst_ready     = chance(60);
            redirect_valid = chance(30);
            halt           = chance(2);
            case ($urandom_range(19, 0))
                0:       redirect_pc = 32'hFFFF_FFFC;
                1:       redirect_pc = $urandom | 32'h1;
                2:       redirect_pc = ($urandom & 32'hFFFF_FFFC) | 32'h2;
                default: redirect_pc = $urandom & 32'hFFFF_FFFC;
            endcase
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25050147_ifu.md
YSYX_25050147_IFU -- requirements
Module: ysyx_25050147_IFU

Interface
REQ-001 Parameter XLEN, default 32, width of PC and fetch address.
REQ-002 Parameter RESET_PC, default 32'h80000000, first fetch address after reset.
REQ-003 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-004 Port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port imem_req_valid  output  1  fetch request valid.
REQ-007 Port imem_req_ready  input  1  memory accepts the request.
REQ-008 Port imem_req_addr  output  XLEN  fetch address.
REQ-009 Port imem_rsp_valid  input  1  fetch response valid; always accepted.
REQ-010 Port imem_rsp_data  input  32  fetched instruction word.
REQ-011 Port imem_rsp_err  input  1  access fault, qualified by imem_rsp_valid.
REQ-012 Port inst_valid  output  1  instruction available to decode.
REQ-013 Port inst_ready  input  1  decode consumes the instruction.
REQ-014 Port inst  output  32  held instruction word.
REQ-015 Port inst_pc  output  XLEN  PC of the held instruction.
REQ-016 Port redirect_valid  input  1  next PC is redirect_pc, not pc+4.
REQ-017 Port redirect_pc  input  XLEN  target for taken branch/jump.
REQ-018 Port halt  input  1  ebreak retired; stop fetching.
REQ-019 Port halted  output  1  IFU stopped (halt or fault).
REQ-020 Port fault  output  1  stop caused by error or misaligned target.
REQ-021 Port inst_count  output  CNT_W  number of retired instructions.

Function
REQ-022 FSM states: REQ, WAIT, HOLD, STOP; only REQ drives imem_req_valid=1, only HOLD drives inst_valid=1, only STOP drives halted=1.
REQ-023 REQ: imem_req_addr=pc; on imem_req_valid & imem_req_ready -> WAIT; addr and valid stable until accepted.
REQ-024 WAIT: imem_rsp_valid & !imem_rsp_err -> latch imem_rsp_data into inst, inst_pc=pc, -> HOLD.
REQ-025 WAIT: imem_rsp_valid & imem_rsp_err -> fault=1, -> STOP; instruction not presented.
REQ-026 A response arriving in the same cycle as request acceptance is not legal; earliest response is the cycle after acceptance.
REQ-027 HOLD: inst/inst_pc stable until inst_ready; retire = inst_valid & inst_ready.
REQ-028 redirect_valid and halt sampled only on retire; ignored in all other cycles.
REQ-029 On retire: halt=1 -> STOP (fault stays 0), pc unchanged; halt takes priority over redirect.
REQ-030 On retire, no halt: redirect_valid=1 -> next pc=redirect_pc, else pc+4 (mod 2^XLEN, wraps silently); -> REQ.
REQ-031 On retire with redirect_valid=1 and redirect_pc[1:0]!=0 -> fault=1, -> STOP, pc unchanged.
REQ-032 inst_count increments by 1 on every retire, including the halting one; wraps to 0 at 2^CNT_W.
REQ-033 STOP is terminal: no requests, inst_valid=0, outputs hold until reset.
REQ-034 Minimum retire interval: 3 cycles (REQ, WAIT, HOLD) with zero-wait memory and inst_ready=1.

Reset
REQ-035 rst=1 immediately forces state=REQ, pc=RESET_PC, inst=0, inst_pc=0, inst_count=0, fault=0, halted=0, inst_valid=0.
REQ-036 imem_req_valid is forced 0 while rst=1 and rises in the first cycle after deassertion.
REQ-037 Reset mid-transaction (WAIT/HOLD) abandons the transaction; a late response after deassertion while in REQ is ignored.

Verification
REQ-038 Reset release, zero-wait memory, inst_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 fetched, one retire per 3 cycles, inst_count=3 after third retire.
REQ-039 imem_req_ready low 4 cycles, then inst_ready low 2 cycles -> imem_req_addr and inst/inst_pc stable throughout, no duplicate or lost retire.
REQ-040 Retire at 0x80000004 with redirect_valid=1, redirect_pc=0x80000100 -> next request addr 0x80000100; redirect_valid asserted outside retire has no effect.
REQ-041 Retire with halt=1 and redirect_valid=1 -> halted=1, fault=0, no further imem_req_valid, inst_count incremented once.
REQ-042 Response with imem_rsp_err=1 -> fault=1, halted=1, inst_valid never 1; redirect_pc=0x80000102 on retire -> fault=1, halted=1.
REQ-043 rst asserted in WAIT, response delivered during reset -> after release first request addr is 0x80000000, inst_count=0.
